// File: rtl/mem_rdata_stage.sv
// Memory read-data pipeline stage: waits for the cache response, extracts and extends load data.
// Optional macro MEM_RDATA_LOAD_FWD_EN: forward load results as soon as their data arrives.
module mem_rdata_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        excep_flush_i,
  input  logic        pre_to_now_valid_i,
  output logic        now_allowin_o,
  input  logic        next_allowin_i,
  output logic        now_to_next_valid_o,
  input  logic        pre_mem_req_i,
  input  logic        pre_mem_we_i,
  input  logic [2:0]  pre_load_type_i,
  input  logic [1:0]  pre_addr_low2_i,
  input  logic        pre_excep_en_i,
  input  logic        pre_regs_we_i,
  input  logic [4:0]  pre_regs_waddr_i,
  input  logic [31:0] pre_regs_wdata_i,
  input  logic [31:0] pre_pc_i,
  input  logic        data_ok_i,
  input  logic [31:0] rdata_i,
  output logic        regs_we_o,
  output logic [4:0]  regs_waddr_o,
  output logic [31:0] regs_wdata_o,
  output logic [31:0] pc_o,
  output logic        excep_en_o,
  output logic [38:0] forward_obus
);

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  logic        r_valid;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [2:0]  r_load_type;
  logic [1:0]  r_addr_low2;
  logic        r_excep_en;
  logic        r_regs_we;
  logic [4:0]  r_regs_waddr;
  logic [31:0] r_regs_wdata;
  logic [31:0] r_pc;
  logic        r_buf_valid;
  logic [31:0] r_rdata_buf;
  logic        r_discard;

  logic        w_wait;
  logic        w_data_ok_eff;
  logic        w_got_data;
  logic        w_ready_go;
  logic        w_entry;
  logic        w_leave;
  logic        w_buf_set;
  logic        w_is_load;
  logic [31:0] w_src;
  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic        w_fwd_we;
  logic [31:0] w_fwd_wdata;
  logic        w_fwd_stall;

  // A response arriving while discard is set belongs to a flushed instruction.
  assign w_data_ok_eff = data_ok_i & ~r_discard;
  assign w_wait        = r_valid & r_mem_req & ~r_excep_en;
  assign w_got_data    = r_buf_valid | w_data_ok_eff;
  assign w_ready_go    = ~w_wait | w_got_data;
  assign w_entry       = pre_to_now_valid_i & now_allowin_o & ~excep_flush_i;
  assign w_leave       = r_valid & w_ready_go & next_allowin_i;
  assign w_buf_set     = w_wait & w_data_ok_eff & ~next_allowin_i & ~r_buf_valid;
  assign w_is_load     = r_mem_req & ~r_mem_we;

  assign now_allowin_o       = ~r_valid | (w_ready_go & next_allowin_i);
  assign now_to_next_valid_o = r_valid & w_ready_go & ~excep_flush_i;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_load_type  <= 3'b000;
      r_addr_low2  <= 2'b00;
      r_excep_en   <= 1'b0;
      r_regs_we    <= 1'b0;
      r_regs_waddr <= 5'd0;
      r_regs_wdata <= 32'd0;
      r_pc         <= 32'd0;
    end else begin
      if (excep_flush_i)      r_valid <= 1'b0;
      else if (now_allowin_o) r_valid <= pre_to_now_valid_i;
      if (w_entry) begin
        r_mem_req    <= pre_mem_req_i;
        r_mem_we     <= pre_mem_we_i;
        r_load_type  <= pre_load_type_i;
        r_addr_low2  <= pre_addr_low2_i;
        r_excep_en   <= pre_excep_en_i;
        r_regs_we    <= pre_regs_we_i;
        r_regs_waddr <= pre_regs_waddr_i;
        r_regs_wdata <= pre_regs_wdata_i;
        r_pc         <= pre_pc_i;
      end
    end
  end

  // The response buffer holds data that arrived while writeback was stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_valid <= 1'b0;
      r_rdata_buf <= 32'd0;
      r_discard   <= 1'b0;
    end else begin
      if (excep_flush_i | w_leave) begin
        r_buf_valid <= 1'b0;
      end else if (w_buf_set) begin
        r_buf_valid <= 1'b1;
        r_rdata_buf <= rdata_i;
      end
      r_discard <= (r_discard & ~data_ok_i) | (excep_flush_i & w_wait & ~w_got_data);
    end
  end

  assign w_src     = r_buf_valid ? r_rdata_buf : rdata_i;
  assign w_shifted = w_src >> {r_addr_low2, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = r_addr_low2[1] ? w_src[31:16] : w_src[15:0];

  always_comb begin
    w_load_data = w_src;
    case (r_load_type)
      LD_B:    w_load_data = {{24{w_byte[7]}}, w_byte};
      LD_H:    w_load_data = {{16{w_half[15]}}, w_half};
      LD_W:    w_load_data = w_src;
      LD_BU:   w_load_data = {24'd0, w_byte};
      LD_HU:   w_load_data = {16'd0, w_half};
      default: w_load_data = w_src;
    endcase
  end

  assign regs_we_o    = r_regs_we & r_valid & ~r_excep_en & ~excep_flush_i;
  assign regs_waddr_o = r_regs_waddr;
  assign regs_wdata_o = w_is_load ? w_load_data : r_regs_wdata;
  assign pc_o         = r_pc;
  assign excep_en_o   = r_excep_en;

  assign w_fwd_we = r_regs_we & r_valid & ~excep_flush_i;
`ifdef MEM_RDATA_LOAD_FWD_EN
  assign w_fwd_wdata = regs_wdata_o;
  assign w_fwd_stall = r_valid & ~w_ready_go;
`else
  // Loads always stall consumers here, so the raw register value never carries load data.
  assign w_fwd_wdata = r_regs_wdata;
  assign w_fwd_stall = r_valid & w_is_load;
`endif
  assign forward_obus = {w_fwd_we, r_regs_waddr, w_fwd_wdata, w_fwd_stall};

endmodule

// File: tb/tb_mem_rdata_stage.sv
// Self-checking bench for mem_rdata_stage: scoreboard of expected writeback results
// plus directed checks for buffering, flush/discard and asynchronous reset.
module tb_mem_rdata_stage;

  logic        clk;
  logic        rst_n;
  logic        excep_flush_i;
  logic        pre_to_now_valid_i;
  logic        now_allowin_o;
  logic        next_allowin_i;
  logic        now_to_next_valid_o;
  logic        pre_mem_req_i;
  logic        pre_mem_we_i;
  logic [2:0]  pre_load_type_i;
  logic [1:0]  pre_addr_low2_i;
  logic        pre_excep_en_i;
  logic        pre_regs_we_i;
  logic [4:0]  pre_regs_waddr_i;
  logic [31:0] pre_regs_wdata_i;
  logic [31:0] pre_pc_i;
  logic        data_ok_i;
  logic [31:0] rdata_i;
  logic        regs_we_o;
  logic [4:0]  regs_waddr_o;
  logic [31:0] regs_wdata_o;
  logic [31:0] pc_o;
  logic        excep_en_o;
  logic [38:0] forward_obus;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_rdata_stage dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .excep_flush_i       (excep_flush_i),
    .pre_to_now_valid_i  (pre_to_now_valid_i),
    .now_allowin_o       (now_allowin_o),
    .next_allowin_i      (next_allowin_i),
    .now_to_next_valid_o (now_to_next_valid_o),
    .pre_mem_req_i       (pre_mem_req_i),
    .pre_mem_we_i        (pre_mem_we_i),
    .pre_load_type_i     (pre_load_type_i),
    .pre_addr_low2_i     (pre_addr_low2_i),
    .pre_excep_en_i      (pre_excep_en_i),
    .pre_regs_we_i       (pre_regs_we_i),
    .pre_regs_waddr_i    (pre_regs_waddr_i),
    .pre_regs_wdata_i    (pre_regs_wdata_i),
    .pre_pc_i            (pre_pc_i),
    .data_ok_i           (data_ok_i),
    .rdata_i             (rdata_i),
    .regs_we_o           (regs_we_o),
    .regs_waddr_o        (regs_waddr_o),
    .regs_wdata_o        (regs_wdata_o),
    .pc_o                (pc_o),
    .excep_en_o          (excep_en_o),
    .forward_obus        (forward_obus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference load extraction, built from an explicit byte view of the word.
  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [2:0] lt,
                                             input logic [1:0] a);
    logic [7:0]  b [4];
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
    sel_b = b[a];
    sel_h = a[1] ? {b[3], b[2]} : {b[1], b[0]};
    case (lt)
      3'b000:  return {{24{sel_b[7]}}, sel_b};
      3'b001:  return {{16{sel_h[15]}}, sel_h};
      3'b100:  return {24'd0, sel_b};
      3'b101:  return {16'd0, sel_h};
      default: return rd;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && now_to_next_valid_o && next_allowin_i) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_out", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_we",    {63'd0, regs_we_o},   {63'd0, mon_e.we});
        check("sb_waddr", {59'd0, regs_waddr_o}, {59'd0, mon_e.waddr});
        check("sb_wdata", {32'd0, regs_wdata_o}, {32'd0, mon_e.wdata});
        check("sb_pc",    {32'd0, pc_o},         {32'd0, mon_e.pc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one instruction, waits (bounded) for acceptance; returns with it in the stage.
  task automatic issue(input logic mem_req, input logic we, input logic [2:0] lt,
                       input logic [1:0] a, input logic rwe, input logic [4:0] waddr,
                       input logic [31:0] wdata, input logic [31:0] pc,
                       input logic push, input logic [31:0] exp_wdata);
    int   n;
    exp_t e;
    pre_to_now_valid_i = 1'b1;
    pre_mem_req_i      = mem_req;
    pre_mem_we_i       = we;
    pre_load_type_i    = lt;
    pre_addr_low2_i    = a;
    pre_excep_en_i     = 1'b0;
    pre_regs_we_i      = rwe;
    pre_regs_waddr_i   = waddr;
    pre_regs_wdata_i   = wdata;
    pre_pc_i           = pc;
    #1;
    n = 0;
    while (!now_allowin_o && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("issue_allowin_timeout", 64'd1, 64'd0);
    if (push) begin
      e.we = rwe; e.waddr = waddr; e.wdata = exp_wdata; e.pc = pc;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    pre_to_now_valid_i = 1'b0;
  endtask

  logic [2:0]  lt_tab [5];
  logic [2:0]  r_lt;
  logic [1:0]  r_a;
  logic [31:0] r_rd;
  logic [31:0] pc;

  initial begin
    lt_tab[0] = 3'b000; lt_tab[1] = 3'b001; lt_tab[2] = 3'b010;
    lt_tab[3] = 3'b100; lt_tab[4] = 3'b101;
    rst_n = 1'b0; excep_flush_i = 1'b0; pre_to_now_valid_i = 1'b0; next_allowin_i = 1'b1;
    pre_mem_req_i = 1'b0; pre_mem_we_i = 1'b0; pre_load_type_i = 3'b000; pre_addr_low2_i = 2'b00;
    pre_excep_en_i = 1'b0; pre_regs_we_i = 1'b0; pre_regs_waddr_i = 5'd0; pre_regs_wdata_i = 32'd0;
    pre_pc_i = 32'd0; data_ok_i = 1'b0; rdata_i = 32'd0; pc = 32'h1000;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_allowin",  {63'd0, now_allowin_o},       64'd1);
    check("rst_valid",    {63'd0, now_to_next_valid_o}, 64'd0);
    check("rst_regs_we",  {63'd0, regs_we_o},           64'd0);
    check("rst_fwd",      {25'd0, forward_obus},        64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Non-memory add: one-cycle latency, no forward stall
    issue(1'b0, 1'b0, 3'b010, 2'b00, 1'b1, 5'd5, 32'h1234, pc, 1'b1, 32'h1234);
    @(negedge clk);
    check("add_valid", {63'd0, now_to_next_valid_o}, 64'd1);
    check("add_stall", {63'd0, forward_obus[0]},     64'd0);
    check("add_fwd_we", {63'd0, forward_obus[38]},   64'd1);
    tick(); pc += 4;

    // ld.b offset 3, data_ok on first cycle in the stage
    issue(1'b1, 1'b0, 3'b000, 2'd3, 1'b1, 5'd6, 32'h0, pc, 1'b1, 32'hFFFF_FF80);
    data_ok_i = 1'b1; rdata_i = 32'h80FF_FF12;
    @(negedge clk);
    check("ldb_valid", {63'd0, now_to_next_valid_o}, 64'd1);
    tick(); data_ok_i = 1'b0; pc += 4;

    // ld.hu offset 2
    issue(1'b1, 1'b0, 3'b101, 2'd2, 1'b1, 5'd7, 32'h0, pc, 1'b1, 32'h0000_8001);
    data_ok_i = 1'b1; rdata_i = 32'h8001_0000;
    tick(); data_ok_i = 1'b0; pc += 4;

    // ld.w buffered while writeback stalls for 3 cycles
    next_allowin_i = 1'b0;
    issue(1'b1, 1'b0, 3'b010, 2'd0, 1'b1, 5'd8, 32'h0, pc, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("buf_wait_stall", {63'd0, forward_obus[0]},     64'd1);
    check("buf_wait_valid", {63'd0, now_to_next_valid_o}, 64'd0);
    tick();
    data_ok_i = 1'b1; rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check("buf_rsp_valid",   {63'd0, now_to_next_valid_o}, 64'd1);
    check("buf_rsp_allowin", {63'd0, now_allowin_o},       64'd0);
    tick();
    data_ok_i = 1'b0; rdata_i = 32'h5555_5555;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("buf_hold_valid", {63'd0, now_to_next_valid_o}, 64'd1);
      tick();
    end
    next_allowin_i = 1'b1;
    tick();
    @(negedge clk);
    check("buf_drained", {63'd0, now_to_next_valid_o}, 64'd0);
    tick(); pc += 4;

    // Flush while waiting; new ld.w enters later; first response dropped
    issue(1'b1, 1'b0, 3'b010, 2'd0, 1'b1, 5'd9, 32'h0, pc, 1'b0, 32'h0);
    tick();
    excep_flush_i = 1'b1;
    @(negedge clk);
    check("flush_valid", {63'd0, now_to_next_valid_o}, 64'd0);
    tick(); excep_flush_i = 1'b0; pc += 4;
    issue(1'b1, 1'b0, 3'b010, 2'd0, 1'b1, 5'd10, 32'h0, pc, 1'b1, 32'h2222_2222);
    data_ok_i = 1'b1; rdata_i = 32'h1111_1111;
    @(negedge clk);
    check("drop_valid", {63'd0, now_to_next_valid_o}, 64'd0);
    tick();
    rdata_i = 32'h2222_2222;
    @(negedge clk);
    check("second_rsp_valid", {63'd0, now_to_next_valid_o}, 64'd1);
    tick(); data_ok_i = 1'b0; pc += 4;

    // Flush, then the stale response arrives in the same cycle a new load enters
    issue(1'b1, 1'b0, 3'b010, 2'd0, 1'b1, 5'd11, 32'h0, pc, 1'b0, 32'h0);
    excep_flush_i = 1'b1;
    tick(); excep_flush_i = 1'b0; pc += 4;
    data_ok_i = 1'b1; rdata_i = 32'h4444_4444;
    issue(1'b1, 1'b0, 3'b001, 2'd0, 1'b1, 5'd12, 32'h0, pc, 1'b1, 32'hFFFF_9333);
    data_ok_i = 1'b0;
    @(negedge clk);
    check("same_cycle_wait", {63'd0, now_to_next_valid_o}, 64'd0);
    tick();
    data_ok_i = 1'b1; rdata_i = 32'h0000_9333;
    tick(); data_ok_i = 1'b0; pc += 4;

    // Store waits for data_ok, rdata ignored
    issue(1'b1, 1'b1, 3'b010, 2'd0, 1'b0, 5'd0, 32'hCAFE, pc, 1'b1, 32'hCAFE);
    @(negedge clk);
    check("store_wait", {63'd0, now_to_next_valid_o}, 64'd0);
    tick();
    data_ok_i = 1'b1; rdata_i = 32'hFFFF_FFFF;
    tick(); data_ok_i = 1'b0; pc += 4;

    // Randomised loads with variable response delay
    for (int k = 0; k < 12; k++) begin
      int d;
      r_lt = lt_tab[$urandom_range(0, 4)];
      r_a  = 2'($urandom_range(0, 3));
      r_rd = $urandom;
      d    = $urandom_range(0, 2);
      issue(1'b1, 1'b0, r_lt, r_a, 1'b1, 5'(k + 1), 32'h0, pc, 1'b1, model_load(r_rd, r_lt, r_a));
      repeat (d) tick();
      data_ok_i = 1'b1; rdata_i = r_rd;
      tick(); data_ok_i = 1'b0; rdata_i = 32'h0; pc += 4;
    end

    // Asynchronous reset mid-wait, then a stray response
    issue(1'b1, 1'b0, 3'b010, 2'd0, 1'b1, 5'd13, 32'h0, pc, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_allowin", {63'd0, now_allowin_o},       64'd1);
    check("arst_valid",   {63'd0, now_to_next_valid_o}, 64'd0);
    check("arst_fwd",     {25'd0, forward_obus},        64'd0);
    check("arst_pc",      {32'd0, pc_o},                64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    data_ok_i = 1'b1; rdata_i = 32'h7777_7777;
    @(negedge clk);
    check("stray_valid", {63'd0, now_to_next_valid_o}, 64'd0);
    tick(); data_ok_i = 1'b0;

    repeat (3) tick();
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_rdata_stage.md
MEM_RDATA_STAGE -- requirements
Module: mem_rdata_stage

Interface
REQ-001 SHALL: clk  in  1  sole clock, rising edge.
REQ-002 SHALL: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: excep_flush_i  in  1  exception flush from commit.
REQ-004 SHALL: pre_to_now_valid_i  in  1  upstream MMCb stage has an instruction.
REQ-005 SHALL: now_allowin_o  out  1  stage may accept an instruction.
REQ-006 SHALL: next_allowin_i  in  1  writeback stage may accept an instruction.
REQ-007 SHALL: now_to_next_valid_o  out  1  stage offers a finished instruction.
REQ-008 SHALL: pre_mem_req_i  in  1  instruction issued a cache request.
REQ-009 SHALL: pre_mem_we_i  in  1  request is a store.
REQ-010 SHALL: pre_load_type_i  in  3  load width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-011 SHALL: pre_addr_low2_i  in  2  byte offset of the access.
REQ-012 SHALL: pre_excep_en_i  in  1  instruction carries an exception.
REQ-013 SHALL: pre_regs_we_i / pre_regs_waddr_i / pre_regs_wdata_i  in  1/5/32  register write info.
REQ-014 SHALL: pre_pc_i  in  32  instruction PC.
REQ-015 SHALL: data_ok_i / rdata_i  in  1/32  cache response; it cannot be back-pressured.
REQ-016 SHALL: regs_we_o / regs_waddr_o / regs_wdata_o  out  1/5/32  register write info to writeback.
REQ-017 SHALL: pc_o / excep_en_o  out  32/1  registered pass-through.
REQ-018 SHALL: forward_obus  out  39  {we, waddr[4:0], wdata[31:0], stall}.

Function
REQ-019 SHALL latch all pre_* fields, and set valid, on a rising edge when pre_to_now_valid_i & now_allowin_o & ~excep_flush_i.
REQ-020 SHALL define wait = valid & mem_req & ~excep_en; ready_go = ~wait | got_data, with got_data = buf_valid | (data_ok_i & ~discard).
REQ-021 SHALL drive now_allowin_o = ~valid | (ready_go & next_allowin_i), and now_to_next_valid_o = valid & ready_go & ~excep_flush_i.
REQ-022 SHALL, when data_ok_i is accepted while valid & wait & ~next_allowin_i, capture rdata_i into rdata_buf and set buf_valid; buf_valid SHALL clear when the instruction leaves the stage or on flush.
REQ-023 SHALL, on excep_flush_i, clear valid; if the instruction was waiting with no data received, it SHALL set discard.
REQ-024 SHALL, while discard=1, drop the next data_ok_i, clear discard, and not count that response for any newly entered instruction.
REQ-025 SHALL handle discard clear and a new entry in the same cycle, with the new instruction still waiting for its own data_ok.
REQ-026 SHALL select the load data source as buf_valid ? rdata_buf : rdata_i.
REQ-027 SHALL extract the byte at offset addr_low2*8 and the halfword at offset addr_low2[1]*16.
REQ-028 SHALL sign-extend codes 000/001, zero-extend codes 100/101, and pass code 010 unchanged.
REQ-029 SHALL drive regs_wdata_o with the extended load data when mem_req & ~mem_we, and with regs_wdata otherwise.
REQ-030 SHALL drive regs_we_o = regs_we & valid & ~excep_en & ~excep_flush_i.
REQ-031 SHALL treat a store as waiting for data_ok_i, with its rdata ignored.
REQ-032 SHALL make outputs combinational from state and inputs; latency SHALL be one cycle for non-memory instructions and until data_ok for memory instructions.

Reset
REQ-033 SHALL, on rst_n low, asynchronously clear valid, buf_valid, discard, rdata_buf and all latched fields to 0.
REQ-034 SHALL hold, during reset, now_to_next_valid_o=0, regs_we_o=0, forward_obus=0 and now_allowin_o=1.

Configuration
REQ-035 SHALL, with MEM_RDATA_LOAD_FWD_EN defined, forward a load's extended data with stall=0 once ready_go=1, and with stall=valid & ~ready_go before then.
REQ-036 SHALL, without MEM_RDATA_LOAD_FWD_EN, assert stall = valid & mem_req & ~mem_we for every load, and only forward non-load results.
REQ-037 SHALL drive forward we = regs_we & valid & ~excep_flush_i in both configurations.

Verification
REQ-038 SHALL cover: ld.b, addr_low2=3, rdata=0x80FF_FF12, data_ok the cycle after entry -> regs_wdata_o=0xFFFF_FF80, valid out that cycle.
REQ-039 SHALL cover: ld.hu, addr_low2=2, rdata=0x8001_0000 -> regs_wdata_o=0x0000_8001.
REQ-040 SHALL cover: ld.w, data_ok while next_allowin_i=0 for 3 cycles -> buffered, and the correct word is issued when allowin rises, with no second data_ok needed.
REQ-041 SHALL cover: flush while a load waits, a new ld.w enters, two data_ok pulses arrive -> the first is dropped and the second is written.
REQ-042 SHALL cover: a non-memory add with regs_wdata=0x1234 -> issued after 1 cycle, regs_we_o=1, forward stall=0.
REQ-043 SHALL cover: rst_n low mid-wait -> all state clears immediately, and a later stray data_ok is ignored because the stage is empty.
